// File: rtl/gyro_pkg.sv
// Shared types and register map for the gyro SPI front end.
package gyro_pkg;

    typedef enum logic [2:0] {PWRUP, CFG, WAIT_INT, RD_L, RD_H} state_t;

    // Gyro register addresses
    localparam logic [6:0] INT1_CTRL = 7'h0D;
    localparam logic [6:0] CTRL2_G   = 7'h11;
    localparam logic [6:0] CTRL3_C   = 7'h12;
    localparam logic [6:0] OUTZ_L_G  = 7'h26;
    localparam logic [6:0] OUTZ_H_G  = 7'h27;

    // Configuration data: DRDY on INT1, 208 Hz / 250 dps, block data update
    localparam logic [7:0] INT1_CTRL_VAL = 8'h02;
    localparam logic [7:0] CTRL2_G_VAL   = 8'h50;
    localparam logic [7:0] CTRL3_C_VAL   = 8'h40;

    function automatic logic [15:0] wr_cmd(input logic [6:0] addr, input logic [7:0] data);
        return {1'b0, addr, data};
    endfunction

    function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
        return {1'b1, addr, 8'h00};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI master, mode 3, MSB first. SCLK idles high; MOSI changes on
// SCLK fall, MISO sampled on SCLK rise. Half-period porches around the frame.
module spi_mnrch #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int HALF = SCLK_DIV / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FRONT, S_LOW, S_HIGH, S_BACK} spi_st_t;

    spi_st_t     st, st_nxt;
    logic [CW-1:0] cnt;
    logic [4:0]  bit_cnt;
    logic [15:0] tx_sr;
    logic [7:0]  rx_sr;
    logic        tick;

    // Every phase (porches, SCLK low, SCLK high) lasts HALF cycles
    assign tick    = (cnt == CW'(HALF - 1));
    assign rd_data = rx_sr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) st <= S_IDLE;
        else     st <= st_nxt;
    end

    // Phase sequencing; the frame ends after the 16th full SCLK period
    always_comb begin
        st_nxt = st;
        case (st)
            S_IDLE:  if (wrt)  st_nxt = S_FRONT;
            S_FRONT: if (tick) st_nxt = S_LOW;
            S_LOW:   if (tick) st_nxt = S_HIGH;
            S_HIGH:  if (tick) st_nxt = (bit_cnt == 5'd16) ? S_BACK : S_LOW;
            S_BACK:  if (tick) st_nxt = S_IDLE;
            default: st_nxt = S_IDLE;
        endcase
    end

    // Pin drivers, shift registers and phase counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            SS_n    <= 1'b1;
            SCLK    <= 1'b1;
            MOSI    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= (st == S_IDLE || tick) ? '0 : cnt + 1'b1;
            case (st)
                S_IDLE: if (wrt) begin
                    tx_sr   <= cmd;
                    bit_cnt <= '0;
                    SS_n    <= 1'b0;
                end
                S_FRONT: if (tick) begin
                    SCLK  <= 1'b0;
                    MOSI  <= tx_sr[15];
                    tx_sr <= {tx_sr[14:0], 1'b0};
                end
                S_LOW: if (tick) begin
                    SCLK    <= 1'b1;
                    rx_sr   <= {rx_sr[6:0], MISO};
                    bit_cnt <= bit_cnt + 5'd1;
                end
                S_HIGH: if (tick && bit_cnt != 5'd16) begin
                    SCLK  <= 1'b0;
                    MOSI  <= tx_sr[15];
                    tx_sr <= {tx_sr[14:0], 1'b0};
                end
                S_BACK: if (tick) begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gyro_spi_intf.sv
// Gyro front end: power-up wait, three config writes, then one Z-rate read
// pair (low byte, high byte) per data-ready interrupt.
module gyro_spi_intf
    import gyro_pkg::*;
#(
    parameter int PWRUP_CYC = 65535,
    parameter int SCLK_DIV  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               INT,
    input  logic               MISO,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI,
    output logic               vld,
    output logic signed [15:0] yaw_rt
);

    state_t      state, state_nxt;
    logic [15:0] pwr_cnt;
    logic [1:0]  cfg_idx;
    logic [7:0]  low_byte;
    logic        int_ff1, int_ff2;
    logic        wrt, done;
    logic [15:0] cmd;
    logic [7:0]  rd_data;

    spi_mnrch #(.SCLK_DIV(SCLK_DIV)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= PWRUP;
        else     state <= state_nxt;
    end

    // Sequencer: each command is launched in the cycle the previous frame's
    // done is seen, so frames run back to back
    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        cmd       = '0;
        case (state)
            PWRUP: if (pwr_cnt == 16'(PWRUP_CYC)) begin
                wrt       = 1'b1;
                cmd       = wr_cmd(INT1_CTRL, INT1_CTRL_VAL);
                state_nxt = CFG;
            end
            CFG: if (done) begin
                if (cfg_idx == 2'd0) begin
                    wrt = 1'b1;
                    cmd = wr_cmd(CTRL2_G, CTRL2_G_VAL);
                end else if (cfg_idx == 2'd1) begin
                    wrt = 1'b1;
                    cmd = wr_cmd(CTRL3_C, CTRL3_C_VAL);
                end else begin
                    state_nxt = WAIT_INT;
                end
            end
            WAIT_INT: if (int_ff2) begin
                wrt       = 1'b1;
                cmd       = rd_cmd(OUTZ_L_G);
                state_nxt = RD_L;
            end
            RD_L: if (done) begin
                wrt       = 1'b1;
                cmd       = rd_cmd(OUTZ_H_G);
                state_nxt = RD_H;
            end
            RD_H: if (done) state_nxt = WAIT_INT;
            default: state_nxt = PWRUP;
        endcase
    end

    // INT synchronizer, power-up counter, config index and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            int_ff1  <= 1'b0;
            int_ff2  <= 1'b0;
            pwr_cnt  <= '0;
            cfg_idx  <= '0;
            low_byte <= '0;
            yaw_rt   <= '0;
            vld      <= 1'b0;
        end else begin
            int_ff1 <= INT;
            int_ff2 <= int_ff1;
            vld     <= 1'b0;
            if (state == PWRUP && pwr_cnt != 16'(PWRUP_CYC))
                pwr_cnt <= pwr_cnt + 16'd1;
            if (state == CFG && done)
                cfg_idx <= cfg_idx + 2'd1;
            if (state == RD_L && done)
                low_byte <= rd_data;
            if (state == RD_H && done) begin
                yaw_rt <= $signed({rd_data, low_byte});
                vld    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gyro_spi_intf.sv
// Bench for gyro_spi_intf: SPI slave model, frame/yaw scoreboards, table of
// read vectors plus hand-written held-INT and mid-read-reset sequences.
module tb_gyro_spi_intf;

    localparam int HALF      = 16;
    localparam int FRAME_LEN = 16 * 32 + 32;          // SS_n low time per frame
    localparam int LAT       = 2 + 2 * FRAME_LEN + 2; // INT-to-vld latency

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] yaw;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               INT = 1'b0;
    logic               MISO = 1'b0;
    logic               SS_n, SCLK, MOSI, vld;
    logic signed [15:0] yaw_rt;

    gyro_spi_intf #(.PWRUP_CYC(16), .SCLK_DIV(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .INT    (INT),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .vld    (vld),
        .yaw_rt (yaw_rt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboards
    logic [15:0] frm_q[$];
    logic [15:0] yaw_q[$];

    // Slave model / monitor state
    logic [7:0]  resp_lo = 8'h00, resp_hi = 8'h00, resp_byte = 8'h00;
    logic [15:0] s_word = '0;
    logic [15:0] last_yaw = '0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_vld = 1'b0, prev_done = 1'b0;
    int s_bits = 0, ss_len = 0, front = -1, cyc = 0, last_rise = 0;
    int tim_err = 0, stab_err = 0, done_err = 0, done_cnt = 0;
    int frm_cnt = 0, aborted = 0, vld_cnt = 0;
    int first_len = -1, first_front = -1;

    // SPI slave + output monitor, sampled on the inactive clock edge
    always @(negedge clk) begin
        cyc++;
        if (prev_ss && !SS_n) begin
            s_bits = 0; s_word = '0; ss_len = 0; front = -1; resp_byte = 8'h00;
        end
        if (!SS_n) begin
            ss_len++;
            if (prev_sclk && !SCLK) begin
                if (s_bits == 0) front = ss_len - 1;
                if (s_bits == 8)
                    resp_byte = (s_word[7:0] == 8'hA6) ? resp_lo :
                                (s_word[7:0] == 8'hA7) ? resp_hi : 8'h00;
                MISO = (s_bits >= 8 && s_bits < 16) ? resp_byte[15 - s_bits] : 1'b0;
            end
            if (!prev_sclk && SCLK) begin
                s_word = {s_word[14:0], MOSI};
                s_bits++;
                if (s_bits > 1 && cyc - last_rise != 32) tim_err++;
                last_rise = cyc;
            end
        end
        if (!prev_ss && SS_n) begin
            if (s_bits == 16) begin
                frm_cnt++;
                if (ss_len != FRAME_LEN || front != HALF) tim_err++;
                if (first_len < 0) begin first_len = ss_len; first_front = front; end
                chk("frame_pending", frm_q.size() != 0, 1);
                if (frm_q.size() != 0) chk("frame", s_word, frm_q.pop_front());
            end else begin
                aborted++;
            end
        end
        if (SS_n && !SCLK) tim_err++;
        if (dut.u_spi.done) begin
            done_cnt++;
            if (prev_done) done_err++;
        end
        if (vld) begin
            vld_cnt++;
            if (prev_vld) stab_err++;
            chk("yaw_pending", yaw_q.size() != 0, 1);
            if (yaw_q.size() != 0) chk("yaw_rt", {16'h0, yaw_rt}, yaw_q.pop_front());
        end else if (!rst && yaw_rt !== last_yaw) begin
            stab_err++;
        end
        last_yaw  = yaw_rt;
        prev_vld  = vld;
        prev_done = dut.u_spi.done;
        prev_ss   = SS_n;
        prev_sclk = SCLK;
    end

    task automatic push_cfg();
        frm_q.push_back(16'h0D02);
        frm_q.push_back(16'h1150);
        frm_q.push_back(16'h1240);
    endtask

    task automatic wait_q(input int bound, input string nm);
        int k = 0;
        while ((frm_q.size() != 0 || yaw_q.size() != 0) && k < bound) begin
            @(posedge clk); #1; k++;
        end
        chk(nm, frm_q.size() + yaw_q.size(), 0);
    endtask

    // Edges from reset release until SS_n is seen low
    task automatic count_pwrup(input string nm);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (SS_n && n < 100);
        chk(nm, n, 17);
    endtask

    vec_t vt[5];

    initial begin
        int v0, a0, k, nv, nf, t1, t2;
        logic pss;

        vt[0] = '{8'h34, 8'h12, 16'h1234};
        vt[1] = '{8'h00, 8'h80, 16'h8000};
        vt[2] = '{8'hFF, 8'hFF, 16'hFFFF};
        vt[3] = '{8'h01, 8'h00, 16'h0001};
        vt[4] = '{8'hFE, 8'h7F, 16'h7FFE};

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst_SS_n", SS_n, 1);
        chk("rst_SCLK", SCLK, 1);
        chk("rst_MOSI", MOSI, 0);
        chk("rst_vld", vld, 0);
        chk("rst_yaw", {16'h0, yaw_rt}, 0);

        // Power-up and configuration writes
        push_cfg();
        rst = 1'b0;
        count_pwrup("pwrup_ss_fall");
        wait_q(2000, "cfg_frames");
        chk("frame_ss_len", first_len, FRAME_LEN);
        chk("front_porch", first_front, HALF);
        chk("cfg_done_cnt", done_cnt, 3);

        // Table of single read pairs
        for (int i = 0; i < 5; i++) begin
            int lat;
            resp_lo = vt[i].lo;
            resp_hi = vt[i].hi;
            frm_q.push_back(16'hA600);
            frm_q.push_back(16'hA700);
            yaw_q.push_back(vt[i].yaw);
            v0 = vld_cnt;
            @(posedge clk); #1;
            INT = 1'b1;
            lat = 0;
            while (!vld && lat < LAT + 100) begin
                @(posedge clk); #1; lat++;
                if (lat == 2) INT = 1'b0;
            end
            // lat counts edges from the first one that samples INT up to and
            // including the edge that raises vld
            chk("int_to_vld", lat - 1, LAT);
            repeat (600) @(posedge clk);
            #1;
            chk("one_vld", vld_cnt - v0, 1);
            chk("yaw_hold", {16'h0, yaw_rt}, {16'h0, vt[i].yaw});
            chk("no_extra_frames", frm_q.size() + yaw_q.size(), 0);
        end

        // INT held high: three back-to-back read pairs
        resp_lo = 8'h5A;
        resp_hi = 8'hC3;
        repeat (3) begin
            frm_q.push_back(16'hA600);
            frm_q.push_back(16'hA700);
            yaw_q.push_back(16'hC35A);
        end
        v0 = vld_cnt;
        @(posedge clk); #1;
        INT = 1'b1;
        k = 0; nv = 0; t1 = 0; t2 = 0;
        while (nv < 2 && k < 3 * LAT) begin
            @(posedge clk); #1; k++;
            if (vld) begin
                nv++;
                if (nv == 1) t1 = k; else t2 = k;
            end
        end
        INT = 1'b0;
        while (nv < 3 && k < 4 * LAT) begin
            @(posedge clk); #1; k++;
            if (vld) nv++;
        end
        chk("held_gap", t2 - t1, 2 * FRAME_LEN + 3);
        repeat (600) @(posedge clk);
        #1;
        chk("held_vld_cnt", vld_cnt - v0, 3);
        chk("held_frames", frm_q.size() + yaw_q.size(), 0);
        chk("held_yaw", {16'h0, yaw_rt}, 32'h0000C35A);

        // Reset in the middle of the high-byte read
        resp_lo = 8'h11;
        resp_hi = 8'h22;
        frm_q.push_back(16'hA600);
        v0 = vld_cnt;
        a0 = aborted;
        @(posedge clk); #1;
        INT = 1'b1;
        k = 0; nf = 0; pss = 1'b1;
        while (nf < 2 && k < 2 * LAT) begin
            @(posedge clk); #1; k++;
            if (k == 2) INT = 1'b0;
            if (pss && !SS_n) nf++;
            pss = SS_n;
        end
        repeat (200) @(posedge clk);
        #1;
        chk("mid_frame_active", SS_n, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_SS_n", SS_n, 1);
        chk("abort_SCLK", SCLK, 1);
        repeat (2) @(posedge clk);
        #1;
        push_cfg();
        rst = 1'b0;
        count_pwrup("repwrup_ss_fall");
        wait_q(2500, "restart_cfg");
        chk("abort_cnt", aborted - a0, 1);
        chk("abort_no_vld", vld_cnt - v0, 0);

        // Accumulated protocol checks
        chk("sclk_timing_err", tim_err, 0);
        chk("yaw_stability_err", stab_err, 0);
        chk("done_width_err", done_err, 0);
        chk("done_vs_frames", done_cnt, frm_cnt);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
